// File: rtl/pwm_output_stage.sv
// Five-register control file driving 16 chip outputs as static-high, PWM or low.
// The duty cycle is double-buffered: it only takes effect at a period boundary.
module pwm_output_stage #(
  parameter int unsigned CLK_DIV  = 13,
  parameter int unsigned NUM_REGS = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_valid,
  input  logic [6:0]  wr_addr,
  input  logic [7:0]  wr_data,
  output logic [15:0] out,
  output logic        period_start,
  output logic [7:0]  duty_active
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [15:0]      en_out_q, en_out_d;
  logic [15:0]      en_pwm_q, en_pwm_d;
  logic [7:0]       duty_reg_q, duty_reg_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [7:0]       duty_active_q, duty_active_d;
  logic [15:0]      out_q, out_d;
  logic             period_start_q, period_start_d;

  logic tick;
  logic boundary;
  logic pwm_sig;

  always_comb begin
    en_out_d   = en_out_q;
    en_pwm_d   = en_pwm_q;
    duty_reg_d = duty_reg_q;
    if (wr_valid && (wr_addr < 7'(NUM_REGS))) begin
      case (wr_addr)
        7'd0:    en_out_d[7:0]  = wr_data;
        7'd1:    en_out_d[15:8] = wr_data;
        7'd2:    en_pwm_d[7:0]  = wr_data;
        7'd3:    en_pwm_d[15:8] = wr_data;
        7'd4:    duty_reg_d     = wr_data;
        default: ;
      endcase
    end
  end

  always_comb begin
    tick      = (div_cnt_q == DIV_W'(CLK_DIV - 1));
    boundary  = tick && (cnt_q == 8'hFF);
    div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
    cnt_d     = tick ? cnt_q + 8'd1 : cnt_q;
    // Shadow load uses the pre-write duty_reg_q, so a write landing on the
    // boundary edge waits for the following period.
    duty_active_d  = boundary ? duty_reg_q : duty_active_q;
    period_start_d = boundary;
  end

  always_comb begin
    pwm_sig = (duty_active_q == 8'hFF) || (cnt_q < duty_active_q);
    out_d   = en_out_q & (~en_pwm_q | {16{pwm_sig}});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_out_q       <= '0;
      en_pwm_q       <= '0;
      duty_reg_q     <= '0;
      div_cnt_q      <= '0;
      cnt_q          <= '0;
      duty_active_q  <= '0;
      out_q          <= '0;
      period_start_q <= 1'b0;
    end else begin
      en_out_q       <= en_out_d;
      en_pwm_q       <= en_pwm_d;
      duty_reg_q     <= duty_reg_d;
      div_cnt_q      <= div_cnt_d;
      cnt_q          <= cnt_d;
      duty_active_q  <= duty_active_d;
      out_q          <= out_d;
      period_start_q <= period_start_d;
    end
  end

  assign out          = out_q;
  assign period_start = period_start_q;
  assign duty_active  = duty_active_q;

endmodule

// File: tb/tb_pwm_output_stage.sv
// Bench for pwm_output_stage: arithmetic model checked every cycle, plus
// hand-computed high-time and static-output expectations.
module tb_pwm_output_stage;

  localparam int unsigned CLK_DIV = 2;
  localparam int unsigned PERIOD  = 256 * CLK_DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_valid = 1'b0;
  logic [6:0]  wr_addr = '0;
  logic [7:0]  wr_data = '0;
  logic [15:0] out;
  logic        period_start;
  logic [7:0]  duty_active;

  int errors = 0;
  int checks = 0;

  pwm_output_stage #(.CLK_DIV(CLK_DIV), .NUM_REGS(5)) dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_addr(wr_addr),
    .wr_data(wr_data), .out(out), .period_start(period_start),
    .duty_active(duty_active)
  );

  always #5 clk = ~clk;

  // Model: position in the period comes from the edge count since reset.
  logic [7:0]  mreg [0:4];
  logic [15:0] m_out;
  logic        m_ps;
  logic [7:0]  m_da;
  int unsigned k;

  always @(posedge clk or negedge rst_n) begin : model
    int unsigned cnt_v;
    logic        pwm_v;
    logic [15:0] eo, ep;
    if (!rst_n) begin
      for (int i = 0; i < 5; i++) mreg[i] <= '0;
      m_out <= '0;
      m_ps  <= 1'b0;
      m_da  <= '0;
      k     <= 0;
    end else begin
      cnt_v = (k / CLK_DIV) % 256;
      pwm_v = (m_da == 8'hFF) || (cnt_v < int'(m_da));
      eo = {mreg[1], mreg[0]};
      ep = {mreg[3], mreg[2]};
      for (int i = 0; i < 16; i++)
        m_out[i] <= eo[i] ? (ep[i] ? pwm_v : 1'b1) : 1'b0;
      m_ps <= (k == PERIOD - 1);
      if (k == PERIOD - 1) m_da <= mreg[4];
      if (wr_valid && wr_addr < 7'd5) mreg[wr_addr[2:0]] <= wr_data;
      k <= (k + 1) % PERIOD;
    end
  end

  always @(negedge clk) begin
    checks++;
    if (out !== m_out || period_start !== m_ps || duty_active !== m_da) begin
      errors++;
      $display("FAIL model t=%0t: out=%h ps=%b duty=%h, required out=%h ps=%b duty=%h",
               $time, out, period_start, duty_active, m_out, m_ps, m_da);
    end
  end

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)",
               name, actual, actual, expected, expected);
    end
  endtask

  task automatic wr(input logic [6:0] a, input logic [7:0] d);
    wr_valid = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic wait_ps();
    int n = 0;
    while (period_start !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("wait_period_start", int'(period_start === 1'b1), 1);
  endtask

  // Counts out[0] high samples over one period, optionally writing duty after sample wa.
  task automatic measure(input int wa, input logic [7:0] wd, output int high);
    high = 0;
    for (int i = 1; i <= int'(PERIOD); i++) begin
      @(negedge clk);
      if (out[0]) high++;
      if (i == wa) begin
        wr_valid = 1'b1; wr_addr = 7'd4; wr_data = wd;
      end else begin
        wr_valid = 1'b0;
      end
    end
    wr_valid = 1'b0;
    check("period_len", int'(period_start), 1);
  endtask

  int h;
  int ok_hi, ok_lo, hi_cnt;

  initial begin
    // Reset held while writes are driven.
    @(negedge clk);
    wr(7'd0, 8'hFF);
    wr(7'd4, 8'h80);
    check("rst_out", int'(out), 0);
    check("rst_duty", int'(duty_active), 0);
    check("rst_ps", int'(period_start), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_out", int'(out), 0);

    // Static outputs.
    wr(7'd0, 8'hA5);
    wr(7'd1, 8'h3C);
    check("static_one_edge", int'(out), 16'h00A5);
    @(negedge clk);
    check("static_two_edges", int'(out), 16'h3CA5);
    wr(7'd7, 8'hFF);
    repeat (4) @(negedge clk);
    check("ignored_addr", int'(out), 16'h3CA5);

    // Asynchronous reset between edges.
    #2 rst_n = 1'b0;
    #1 check("async_rst_out", int'(out), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // PWM on bit 0.
    wr(7'd0, 8'h01); wr(7'd1, 8'h00); wr(7'd2, 8'h01); wr(7'd3, 8'h00);
    wr(7'd4, 8'h80);
    wait_ps();
    check("duty_loaded", int'(duty_active), 8'h80);
    measure(0, 8'h00, h);   check("duty_80", h, 256);
    measure(100, 8'h00, h); check("duty_80_before_0", h, 256);
    measure(100, 8'hFF, h); check("duty_00", h, 0);
    measure(100, 8'h01, h); check("duty_FF", h, 512);
    measure(100, 8'h40, h); check("duty_01", h, 2);
    measure(100, 8'hC0, h); check("duty_40", h, 128);
    measure(511, 8'h01, h); check("duty_C0", h, 384);
    measure(0, 8'h00, h);   check("boundary_write_old", h, 384);
    measure(0, 8'h00, h);   check("boundary_write_new", h, 2);

    // Back-to-back writes to every register.
    wr_valid = 1'b1;
    wr_addr = 7'd0; wr_data = 8'hFF; @(negedge clk);
    wr_addr = 7'd1; wr_data = 8'hFF; @(negedge clk);
    wr_addr = 7'd2; wr_data = 8'h0F; @(negedge clk);
    wr_addr = 7'd3; wr_data = 8'h00; @(negedge clk);
    wr_addr = 7'd4; wr_data = 8'h40; @(negedge clk);
    wr_valid = 1'b0;
    wait_ps();
    ok_hi = 1; ok_lo = 1; hi_cnt = 0;
    for (int i = 0; i < int'(PERIOD); i++) begin
      @(negedge clk);
      if (out[15:4] !== 12'hFFF) ok_hi = 0;
      if (out[3:0] !== 4'h0 && out[3:0] !== 4'hF) ok_lo = 0;
      if (out[3:0] == 4'hF) hi_cnt++;
    end
    check("mixed_static_hi", ok_hi, 1);
    check("mixed_in_phase", ok_lo, 1);
    check("mixed_duty_25", hi_cnt, 128);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pwm_output_stage.md
Name: pwm_output_stage

Overview:
Downstream consumer of the SPI register-write peripheral. It holds the five-entry control register file: output enables, PWM-mode enables and duty cycle. It generates an 8-bit-resolution PWM waveform from a prescaled counter. It drives the 16 chip outputs as static-high, PWM or low per bit. Duty-cycle updates are double-buffered so that a period is never truncated or glitched.

Parameters:
CLK_DIV, 13, clk cycles per PWM counter tick (>=1); 13 at 10 MHz gives ~3 kHz PWM.
NUM_REGS, 5, number of implemented register addresses (0..NUM_REGS-1).

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
wr_valid  input  1  single-cycle write strobe from SPI stage
wr_addr  input  7  register address
wr_data  input  8  write data
out  output  16  chip outputs
period_start  output  1  one-cycle pulse when a new PWM period begins
duty_active  output  8  duty value currently in effect (shadow), for observability

Behaviour:
- Register map: 0x00 en_out[7:0]; 0x01 en_out[15:8]; 0x02 en_pwm[7:0]; 0x03 en_pwm[15:8]; 0x04 duty_reg.
- Write: if wr_valid and wr_addr < NUM_REGS, the addressed reg takes wr_data at the next clk edge. Addresses >= NUM_REGS are ignored with no side effect. Back-to-back writes on consecutive cycles are all accepted.
- Reset (async, any time): all regs, prescaler, counter, duty_active, out and period_start go to 0 immediately. The first period starts from cnt=0 after release.
- Prescaler: div_cnt counts 0..CLK_DIV-1 and wraps. tick = (div_cnt == CLK_DIV-1). With CLK_DIV=1, tick is asserted every cycle.
- PWM counter: cnt is 8 bits and increments on tick. It wraps 255->0, so a period is 256*CLK_DIV clk cycles.
- Boundary: when tick and cnt==255, then on the next edge cnt<=0, duty_active<=duty_reg and period_start<=1 for one cycle. period_start is 0 otherwise.
- Simultaneous write to 0x04 on the boundary edge: duty_active loads the pre-write duty_reg value. The new value takes effect at the following boundary.
- pwm_sig (combinational) = (duty_active==8'hFF) OR (cnt < duty_active). duty 0 gives always low. duty 0xFF gives always high, not 255/256.
- Output per bit i, registered with one-cycle latency from the regs/cnt:
  - en_out[i]=0 gives 0.
  - en_out[i]=1 and en_pwm[i]=0 gives 1.
  - en_out[i]=1 and en_pwm[i]=1 gives pwm_sig.
- Enable register writes affect out exactly 2 clk edges after the wr_valid cycle: one edge for the reg write, one for the out register. They are not double-buffered.
- High time per period = duty_active*CLK_DIV clk cycles, for duty in 1..254.

Test Plan:
- Reset/defaults: hold rst_n low and drive writes -> out=0, duty_active=0, period_start never pulses. Assert rst_n mid-period -> out clears without waiting for a clk edge.
- Static outputs (CLK_DIV=2): write 0x00=0xA5, 0x01=0x3C -> out=0x3CA5 two edges after the second write and stays constant. Write 0x07=0xFF -> no change.
- PWM duty (CLK_DIV=2): en_out=0x0001, en_pwm=0x0001, duty=0x80 -> after the first period_start, out[0] is high 256 cycles and low 256 cycles per 512-cycle period.
- Extremes: duty=0x00 -> out[0] constant 0. duty=0xFF -> out[0] constant 1 across wrap. duty=0x01 -> high exactly 2 cycles per period.
- Double buffering: at duty=0x40 mid-period, write duty=0xC0 -> the current period keeps 128 high cycles and the next period has 384. Write 0x04 on the exact boundary cycle -> the old value holds for one more period.
- Mixed/back-to-back: write 0x00..0x04 on 5 consecutive cycles (0xFF,0xFF,0x0F,0x00,0x40) -> all accepted. out[15:4] are static 1, and out[3:0] toggle in phase with 25% duty.
